// File: rtl/count_smoother_if.sv
// count_smoother_if: sample/result bundle between the edge-count latch
// stage and the moving-average filter.
//   sample_strobe  single-cycle sample-accept pulse
//   sample_in      latched edge count (unsigned, 8 bit)
//   flush          synchronous clear of window history
//   avg_out        registered smoothed count
//   avg_valid      one-cycle pulse per evaluated average
//   primed         window holds a full set of samples
// master = sample producer, slave = filter.
interface count_smoother_if;
  logic       sample_strobe;
  logic [7:0] sample_in;
  logic       flush;
  logic [7:0] avg_out;
  logic       avg_valid;
  logic       primed;

  modport master (
    output sample_strobe, sample_in, flush,
    input  avg_out, avg_valid, primed
  );

  modport slave (
    input  sample_strobe, sample_in, flush,
    output avg_out, avg_valid, primed
  );
endinterface

// File: rtl/count_smoother.sv
// count_smoother: moving-average filter over the last DEPTH edge counts.
// Stage 1 updates a circular buffer and running sum on each accepted
// strobe; stage 2 registers sum/DEPTH one cycle later with a valid pulse
// (latency 2, one sample per cycle).
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    count_smoother_if.slave (strobe/sample/flush in, average out)
// Parameters: DEPTH (power of two, 2..64), HYST (hysteresis in counts).
// Optional feature: define COUNT_SMOOTHER_HYST_EN to hold avg_out unless
// the new candidate differs from it by more than HYST.
module count_smoother #(
  parameter int DEPTH = 8,
  parameter int HYST  = 2
) (
  input logic             clk,
  input logic             reset,
  count_smoother_if.slave bus
);

  localparam int LOG2   = $clog2(DEPTH);
  localparam int SUM_W  = 8 + LOG2;
  localparam int FILL_W = LOG2 + 1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);

  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("count_smoother: DEPTH must be a power of two in 2..64");
  end
  if (HYST < 0 || HYST > 255) begin : g_bad_hyst
    $error("count_smoother: HYST must be in 0..255");
  end

  typedef enum logic {FILL, RUN} state_t;

  state_t            state_q, state_d;
  logic              in_run;
  logic              accept;
  logic [7:0]        sample_buf [DEPTH];
  logic [LOG2-1:0]   wr_ptr;
  logic [SUM_W-1:0]  sum;
  logic [FILL_W-1:0] fill_cnt;
  logic              s1_valid;
  logic [7:0]        candidate;
  logic              load_en;
  logic [7:0]        avg_q;
  logic              valid_q;
  logic              primed_q;

  // flush wins over a coincident strobe
  assign accept    = bus.sample_strobe & ~bus.flush;
  assign candidate = sum[SUM_W-1:LOG2];

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: if (accept && fill_cnt == FILL_LAST) state_d = RUN;
      RUN:  if (bus.flush) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_run = (state_q == RUN);
  end

  // History buffer needs no reset: entries are only read once in RUN,
  // by which point every slot has been written since the last clear.
  always_ff @(posedge clk) begin
    if (accept) sample_buf[wr_ptr] <= bus.sample_in;
  end

  // Stage 1: running sum, pointer, fill count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum      <= '0;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      s1_valid <= 1'b0;
    end else if (bus.flush) begin
      sum      <= '0;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (in_run) begin
          sum <= sum - SUM_W'(sample_buf[wr_ptr]) + SUM_W'(bus.sample_in);
        end else begin
          sum      <= sum + SUM_W'(bus.sample_in);
          fill_cnt <= fill_cnt + 1'b1;
        end
      end
    end
  end

`ifdef COUNT_SMOOTHER_HYST_EN
  localparam logic [7:0] HYST_C = 8'(HYST);
  logic       first_out;
  logic [7:0] diff;

  always_comb begin
    diff    = (candidate > avg_q) ? (candidate - avg_q) : (avg_q - candidate);
    load_en = first_out || (diff > HYST_C);
  end

  // first result after reset/flush always loads
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          first_out <= 1'b1;
    else if (bus.flush) first_out <= 1'b1;
    else if (s1_valid)  first_out <= 1'b0;
  end
`else
  always_comb begin
    load_en = 1'b1;
  end
`endif

  // Stage 2: registered average, valid pulse, primed flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avg_q    <= '0;
      valid_q  <= 1'b0;
      primed_q <= 1'b0;
    end else if (bus.flush) begin
      avg_q    <= '0;
      valid_q  <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      valid_q <= s1_valid;
      if (s1_valid) begin
        primed_q <= in_run;
        if (load_en) avg_q <= candidate;
      end
    end
  end

  assign bus.avg_out   = avg_q;
  assign bus.avg_valid = valid_q;
  assign bus.primed    = primed_q;

endmodule

// File: tb/tb_count_smoother.sv
module tb_count_smoother;
  localparam int DEPTH = 8;
  localparam int HYST  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  count_smoother_if bus();

  count_smoother #(.DEPTH(DEPTH), .HYST(HYST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int avg;
    int primed;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   valid_cnt = 0;

  // reference window model
  int m_buf [DEPTH];
  int m_ptr, m_fill, m_out;
  bit m_first;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) m_buf[i] = 0;
    m_ptr   = 0;
    m_fill  = 0;
    m_out   = 0;
    m_first = 1'b1;
  endfunction

  function automatic void model_push(input int v);
    int   s;
    int   cand;
    exp_t e;
    m_buf[m_ptr] = v;
    m_ptr = (m_ptr + 1) % DEPTH;
    if (m_fill < DEPTH) m_fill++;
    s = 0;
    for (int i = 0; i < DEPTH; i++) s += m_buf[i];
    cand = s / DEPTH;
`ifdef COUNT_SMOOTHER_HYST_EN
    if (m_first || (cand > m_out ? cand - m_out : m_out - cand) > HYST) m_out = cand;
`else
    m_out = cand;
`endif
    m_first = 1'b0;
    e.avg    = m_out;
    e.primed = (m_fill == DEPTH) ? 1 : 0;
    e.cyc    = cyc + 2;
    sb.push_back(e);
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("valid_in_reset", int'(bus.avg_valid), 0);
    end else if (bus.avg_valid) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("avg_out", int'(bus.avg_out), e.avg);
        check("primed", int'(bus.primed), e.primed);
        check("latency", cyc, e.cyc);
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      check("missing_valid", 0, 1);
      void'(sb.pop_front());
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input int v);
    bus.sample_strobe = 1'b1;
    bus.sample_in     = 8'(v);
    model_push(v);
    @(posedge clk);
    #1;
    bus.sample_strobe = 1'b0;
  endtask

  task automatic strobe_spaced(input int v, input int n);
    for (int i = 0; i < n; i++) begin
      strobe(v);
      idle(2);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) idle(1);
    if (sb.size() > 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_flush(input bit with_strobe, input int v);
    bus.flush         = 1'b1;
    bus.sample_strobe = with_strobe;
    bus.sample_in     = 8'(v);
    @(posedge clk);
    #1;
    bus.flush         = 1'b0;
    bus.sample_strobe = 1'b0;
    model_clear();
    check("flush_avg", int'(bus.avg_out), 0);
    check("flush_primed", int'(bus.primed), 0);
  endtask

  initial begin
    int vc0;
    bus.sample_strobe = 1'b0;
    bus.sample_in     = '0;
    bus.flush         = 1'b0;
    model_clear();
    reset = 1'b1;
    #12;
    check("rst_avg", int'(bus.avg_out), 0);
    check("rst_valid", int'(bus.avg_valid), 0);
    check("rst_primed", int'(bus.primed), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);

    // fill with spaced 40s: 5,10,...,40, primed on the 8th
    strobe_spaced(40, 8);
    drain();
    check("fill_avg", int'(bus.avg_out), 40);
    check("fill_primed", int'(bus.primed), 1);

    // one outlier, then evict it
    strobe_spaced(120, 1);
    drain();
    check("outlier_avg", int'(bus.avg_out), 50);
    strobe_spaced(40, 8);
    drain();
    check("evict_avg", int'(bus.avg_out), 40);

    // back-to-back 0..15 with pointer wrap
    do_flush(1'b0, 0);
    idle(1);
    vc0 = valid_cnt;
    for (int i = 0; i < 16; i++) strobe(i);
    drain();
    check("burst_pulses", valid_cnt - vc0, 16);
`ifdef COUNT_SMOOTHER_HYST_EN
    check("burst_avg", int'(bus.avg_out), 9);
`else
    check("burst_avg", int'(bus.avg_out), 11);
`endif

    // flush coincident with a strobe drops the sample
    strobe_spaced(40, 8);
    drain();
    check("prime2_avg", int'(bus.avg_out), 40);
    vc0 = valid_cnt;
    do_flush(1'b1, 80);
    idle(4);
    check("flush_drop_pulses", valid_cnt - vc0, 0);
    check("flush_hold_avg", int'(bus.avg_out), 0);
    strobe_spaced(80, 1);
    drain();
    check("post_flush_avg", int'(bus.avg_out), 10);

    // small step: candidate 41
    do_flush(1'b0, 0);
    strobe_spaced(40, 8);
    drain();
    vc0 = valid_cnt;
    strobe_spaced(48, 1);
    drain();
    check("step_pulses", valid_cnt - vc0, 1);
`ifdef COUNT_SMOOTHER_HYST_EN
    check("step_avg", int'(bus.avg_out), 40);
`else
    check("step_avg", int'(bus.avg_out), 41);
`endif

    // async reset with a sample in flight
    strobe(90);
    reset = 1'b1;
    sb.delete();
    model_clear();
    #1;
    check("arst_avg", int'(bus.avg_out), 0);
    check("arst_valid", int'(bus.avg_valid), 0);
    check("arst_primed", int'(bus.primed), 0);
    idle(2);
    reset = 1'b0;
    vc0 = valid_cnt;
    idle(2);
    check("arst_no_pulse", valid_cnt - vc0, 0);
    strobe_spaced(64, 1);
    drain();
    check("arst_new_avg", int'(bus.avg_out), 8);

    idle(3);
    check("queue_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
